// File: rtl/mdrp_responder.sv
// mdrp_responder: MDRP target with a 256x8 auto-incrementing register file and a registered read port.
// Define MDRP_LOCK_MODEL_EN to build the PLL lock model; otherwise O_LOCK is a registered ~I_PLL_RST.
module mdrp_responder
`ifdef MDRP_LOCK_MODEL_EN
#(
  parameter int unsigned LOCK_DLY = 16,
  parameter logic [7:0]  CHK_ADDR = 8'h11,
  parameter logic [7:0]  CHK_MASK = 8'h07,
  parameter logic [7:0]  CHK_VAL  = 8'h07
)
`endif
(
  input  logic       I_MD_CLK,
  input  logic       I_RST_N,
  input  logic       I_MD_INC,
  input  logic [1:0] I_MD_OPC,
  input  logic [7:0] I_MD_WR_DATA,
  output logic [7:0] O_MD_RD_DATA,
  input  logic       I_PLL_RST,
  output logic       O_LOCK,
  output logic [7:0] O_PTR
);

  localparam logic [1:0] OPC_CLR = 2'b00;
  localparam logic [1:0] OPC_WR  = 2'b01;

  logic [7:0] ptr_q, ptr_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] regs_q [256];
  logic       wr_en;
  logic       lock_q, lock_d;

  assign wr_en = (I_MD_OPC == OPC_WR);

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    ptr_d = ptr_q;
    if (I_MD_OPC == OPC_CLR) begin
      ptr_d = '0;
    end else if (I_MD_INC) begin
      ptr_d = ptr_q + 8'd1;
    end
  end

  // Reads use the pre-write contents; a write becomes visible one edge later.
  assign rd_data_d = regs_q[ptr_d];

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      ptr_q     <= '0;
      rd_data_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      rd_data_q <= rd_data_d;
      lock_q    <= lock_d;
    end
  end

  // NOTE: the register file is reset in full because a reset must discard all contents, so it cannot map to RAM.
  always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      for (int i = 0; i < 256; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[ptr_q] <= I_MD_WR_DATA;
    end
  end

`ifdef MDRP_LOCK_MODEL_EN
  localparam int CNT_W = $clog2(LOCK_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DLY - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT,
    ST_LOCK,
    ST_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chk_pass;

  assign chk_pass = ((regs_q[CHK_ADDR] & CHK_MASK) == CHK_VAL);

  // PLL reset outranks a write; a write restarts the settle window from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (I_PLL_RST) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end else if (wr_en) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
        ST_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = chk_pass ? ST_LOCK : ST_FAIL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign lock_d = (state_d == ST_LOCK);

  always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign lock_d = ~I_PLL_RST;
`endif

  assign O_PTR        = ptr_q;
  assign O_MD_RD_DATA = rd_data_q;
  assign O_LOCK       = lock_q;

endmodule

// File: tb/tb_mdrp_responder.sv
// Self-checking bench for mdrp_responder: directed scenarios plus random traffic against a behavioural model.
// Honours MDRP_LOCK_MODEL_EN the same way the design does.
module tb_mdrp_responder;

`ifdef MDRP_LOCK_MODEL_EN
  localparam int LOCK_DLY = 16;
  localparam int CHK_ADDR = 'h11;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0;
  logic [1:0] opc = 2'b10;
  logic [7:0] wd = 8'h00;
  logic       pll_rst = 1'b1;
  logic [7:0] rd;
  logic [7:0] ptr;
  logic       lock;

  always #5 clk = ~clk;

  mdrp_responder dut (
    .I_MD_CLK     (clk),
    .I_RST_N      (rst_n),
    .I_MD_INC     (inc),
    .I_MD_OPC     (opc),
    .I_MD_WR_DATA (wd),
    .O_MD_RD_DATA (rd),
    .I_PLL_RST    (pll_rst),
    .O_LOCK       (lock),
    .O_PTR        (ptr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain array, integer pointer, and "cycles since settle window opened".
  logic [7:0] mem [256];
  int         m_ptr;
  logic [7:0] m_rd;
  logic       m_lock;
  bit         m_hold;
  int         m_since;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    m_ptr   = 0;
    m_rd    = 8'h00;
    m_lock  = 1'b0;
    m_hold  = 1'b1;
    m_since = 0;
  endtask

  task automatic model_edge(input bit i, input logic [1:0] o, input logic [7:0] d, input bit p);
    int nptr;
    nptr = (o == 2'b00) ? 0 : (i ? (m_ptr + 1) % 256 : m_ptr);
    m_rd = mem[nptr];
    if (o == 2'b01) mem[m_ptr] = d;
    m_ptr = nptr;
`ifdef MDRP_LOCK_MODEL_EN
    if (p) begin
      m_hold  = 1'b1;
      m_since = 0;
    end else if (o == 2'b01 || m_hold) begin
      m_hold  = 1'b0;
      m_since = 0;
    end else if (m_since < 100000) begin
      m_since++;
    end
    m_lock = !m_hold && (m_since >= LOCK_DLY) && ((mem[CHK_ADDR] & 8'h07) == 8'h07);
`else
    m_lock = !p;
`endif
  endtask

  task automatic step(input bit i, input logic [1:0] o, input logic [7:0] d, input bit p);
    inc = i;
    opc = o;
    wd = d;
    pll_rst = p;
    @(posedge clk);
    model_edge(i, o, d, p);
    #1;
    check("ptr", ptr, m_ptr);
    check("rd_data", rd, m_rd);
    check("lock", lock, m_lock);
  endtask

  task automatic goto_addr(input int addr, input bit p);
    step(1'b0, 2'b00, 8'h00, p);
    repeat (addr) step(1'b1, 2'b10, 8'h00, p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen;
    bit p;
    model_reset();

    // Reset state, sampled between edges while reset is held.
    #2;
    check("rst_ptr", ptr, 8'h00);
    check("rst_rd", rd, 8'h00);
    check("rst_lock", lock, 1'b0);
    #10 rst_n = 1'b1;

    // Pointer walk and read.
    repeat (8'h11) step(1'b1, 2'b10, 8'h00, 1'b1);
    check("walk_ptr", ptr, 8'h11);
    step(1'b0, 2'b10, 8'h00, 1'b1);
    check("walk_rd", rd, 8'h00);

    // Write then read back.
    goto_addr('h0B, 1'b1);
    step(1'b0, 2'b01, 8'hA5, 1'b1);
    step(1'b1, 2'b10, 8'h00, 1'b1);
    step(1'b0, 2'b01, 8'h3C, 1'b1);
    goto_addr('h0B, 1'b1);
    check("rb_a5", rd, 8'hA5);
    step(1'b1, 2'b10, 8'h00, 1'b1);
    check("rb_3c", rd, 8'h3C);

    // Simultaneous write and increment at the top address.
    goto_addr('hFF, 1'b1);
    step(1'b1, 2'b01, 8'h77, 1'b1);
    check("wrap_ptr", ptr, 8'h00);
    goto_addr('hFF, 1'b1);
    check("wrap_rd", rd, 8'h77);
    step(1'b1, 2'b00, 8'h00, 1'b1);
    check("clr_inc_ptr", ptr, 8'h00);

`ifdef MDRP_LOCK_MODEL_EN
    // Lock pass: release PLL reset, count edges to lock.
    goto_addr('h11, 1'b1);
    step(1'b0, 2'b01, 8'h07, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step(1'b0, 2'b10, 8'h00, 1'b0);
      if (lock === 1'b1) begin
        n = k;
        seen = 1'b1;
      end
    end
    check("lock_latency", n - 1, 16);
    step(1'b0, 2'b01, 8'h07, 1'b0);
    check("lock_drop", lock, 1'b0);
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step(1'b0, 2'b10, 8'h00, 1'b0);
      if (lock === 1'b1) begin
        n = k;
        seen = 1'b1;
      end
    end
    check("relock_latency", n, 16);

    // Lock fail: masked bits do not match.
    step(1'b0, 2'b01, 8'h03, 1'b0);
    repeat (40) step(1'b0, 2'b10, 8'h00, 1'b0);
    check("fail_lock", lock, 1'b0);
    step(1'b0, 2'b10, 8'h00, 1'b1);
    check("fail_hold", lock, 1'b0);
    step(1'b0, 2'b01, 8'h0F, 1'b1);
    repeat (LOCK_DLY) step(1'b0, 2'b10, 8'h00, 1'b0);
    check("hold_relock", lock, 1'b0);
    step(1'b0, 2'b10, 8'h00, 1'b0);
    check("hold_relock_edge", lock, 1'b1);
`else
    step(1'b0, 2'b10, 8'h00, 1'b0);
    check("track_lo", lock, 1'b1);
    step(1'b0, 2'b10, 8'h00, 1'b1);
    check("track_hi", lock, 1'b0);
`endif

    // Asynchronous reset in the middle of the settle window.
    goto_addr('h11, 1'b1);
    step(1'b0, 2'b01, 8'h07, 1'b1);
    step(1'b1, 2'b10, 8'h00, 1'b0);
    step(1'b0, 2'b11, 8'h00, 1'b0);
    step(1'b0, 2'b10, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ptr", ptr, 8'h00);
    check("arst_rd", rd, 8'h00);
    check("arst_lock", lock, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
    goto_addr('h11, 1'b0);
    check("arst_reg11", rd, 8'h00);
    repeat (20) step(1'b0, 2'b10, 8'h00, 1'b0);

    // Random traffic with slowly toggling PLL reset.
    p = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      int r;
      logic [7:0] d;
      logic [1:0] o;
      if ($urandom_range(0, 49) == 0) p = ~p;
      r = $urandom_range(0, 31);
      o = (r == 0) ? 2'b00 : (r <= 3) ? 2'b01 : 2'($urandom_range(2, 3));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) d = d | 8'h07;
      step(1'($urandom_range(0, 1)), o, d, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
